// File: rtl/multi_freq_divider_if.sv
// Control/status bundle for multi_freq_divider: run enables, ratio write port and outputs.
// FDIV_SYNC_EN adds the sync input.
interface multi_freq_divider_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic [CHANNELS-1:0] en;
    logic                div_we;
    logic [SEL_W-1:0]    div_sel;
    logic [DIV_W-1:0]    div_data;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] flag_out;
    logic [CHANNELS-1:0] pend;
    logic                err;
`ifdef FDIV_SYNC_EN
    logic                sync;
`endif

    modport master (
`ifdef FDIV_SYNC_EN
        output sync,
`endif
        output en, div_we, div_sel, div_data,
        input  clk_out, flag_out, pend, err
    );

    modport slave (
`ifdef FDIV_SYNC_EN
        input  sync,
`endif
        input  en, div_we, div_sel, div_data,
        output clk_out, flag_out, pend, err
    );
endinterface

// File: rtl/multi_freq_divider.sv
// Multi-channel programmable divider producing square-wave enables and end-of-period ticks.
// Optional macro FDIV_SYNC_EN adds a sync input that restarts all running channels in phase.
module multi_freq_divider #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned DEF_DIV  = 8
) (
    input  logic                  clk_in,
    input  logic                  rst,
    multi_freq_divider_if.slave   bus
);
    typedef enum logic {StIdle, StRun} state_e;

    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [DIV_W-1:0]    cnt_q   [CHANNELS];
    logic [DIV_W-1:0]    cnt_d   [CHANNELS];
    logic [DIV_W-1:0]    r_q     [CHANNELS];
    logic [DIV_W-1:0]    r_d     [CHANNELS];
    logic [DIV_W-1:0]    shadow_q[CHANNELS];
    logic [DIV_W-1:0]    shadow_d[CHANNELS];
    logic [CHANNELS-1:0] clk_q, clk_d, flag_q, flag_d, pend_q, pend_d;
    logic                err_q, err_d;
    logic                wr_ok;
    logic                sync_pulse;

`ifdef FDIV_SYNC_EN
    assign sync_pulse = bus.sync;
`else
    assign sync_pulse = 1'b0;
`endif

    assign wr_ok = bus.div_we && (32'(bus.div_sel) < CHANNELS) && (bus.div_data >= DIV_W'(2));

    always_comb begin
        logic [DIV_W-1:0] r_new;
        logic [DIV_W-1:0] cnt_nxt;
        r_new    = '0;
        cnt_nxt  = '0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        shadow_d = shadow_q;
        clk_d    = clk_q;
        flag_d   = flag_q;
        pend_d   = pend_q;
        err_d    = bus.div_we && !wr_ok;
        for (int i = 0; i < CHANNELS; i++) begin
            case (state_q[i])
                StIdle: begin
                    if (pend_q[i]) begin
                        r_d[i]    = shadow_q[i];
                        pend_d[i] = 1'b0;
                    end
                    if (bus.en[i]) begin
                        state_d[i] = StRun;
                        cnt_d[i]   = '0;
                        clk_d[i]   = 1'b1;
                        flag_d[i]  = 1'b0;
                    end
                end
                StRun: begin
                    if (!bus.en[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                        clk_d[i]   = 1'b0;
                        flag_d[i]  = 1'b0;
                    end else if (sync_pulse) begin
                        cnt_d[i]  = '0;
                        clk_d[i]  = 1'b1;
                        flag_d[i] = 1'b0;
                        if (pend_q[i]) begin
                            r_d[i]    = shadow_q[i];
                            pend_d[i] = 1'b0;
                        end
                    end else begin
                        r_new   = r_q[i];
                        cnt_nxt = cnt_q[i] + DIV_W'(1);
                        if (cnt_q[i] == r_q[i] - DIV_W'(1)) begin
                            cnt_nxt = '0;
                            if (pend_q[i]) begin
                                r_new     = shadow_q[i];
                                pend_d[i] = 1'b0;
                            end
                        end
                        r_d[i]    = r_new;
                        cnt_d[i]  = cnt_nxt;
                        // High phase is ceil(R/2), written to avoid overflow at R = 2^DIV_W-1
                        clk_d[i]  = cnt_nxt < ((r_new >> 1) + DIV_W'(r_new[0]));
                        flag_d[i] = cnt_nxt == r_new - DIV_W'(1);
                    end
                end
                default: ;
            endcase
            // A write landing on a wrap edge is stored after the old shadow was consumed
            if (wr_ok && (32'(bus.div_sel) == 32'(i))) begin
                shadow_d[i] = bus.div_data;
                pend_d[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= StIdle;
                cnt_q[i]    <= '0;
                r_q[i]      <= DIV_W'(DEF_DIV);
                shadow_q[i] <= DIV_W'(DEF_DIV);
            end
            clk_q  <= '0;
            flag_q <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            shadow_q <= shadow_d;
            clk_q    <= clk_d;
            flag_q   <= flag_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign bus.clk_out  = clk_q;
    assign bus.flag_out = flag_q;
    assign bus.pend     = pend_q;
    assign bus.err      = err_q;
endmodule
